riscvsys_evcnt: RTL
===================

# riscvsys_evcnt

Parametrised retired-instruction event counter bank. It extends the per-instruction event decode to any number of events, each qualified by the retire strobe. Every event has a CNT_W-bit counter with a sticky overflow flag, plus a snapshot shadow bank. A command/response port gives debug software atomic read, clear and snapshot access. The block sits beside the core, fed by its instruction-decode flags, `i_dbg_next` and PC.

## Interface
- `N_EV`, 49: number of event channels; bit order follows the core's instruction-flag order (lui = bit 0 … trap = bit 48).
- `CNT_W`, 32: counter width, 2..64.
- `ADDR_W`, 6: command address width; must satisfy 2^ADDR_W >= N_EV.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_resetn`  in  1  reset, synchronous, active-low.
- `i_ev`  in  N_EV  per-instruction decode flags; several may be high at once.
- `i_dbg_next`  in  1  retire qualifier; events count only when high.
- `i_pc`  in  32  PC of the retiring instruction.
- `i_pc_lo`, `i_pc_hi`  in  32 each  inclusive PC filter window; used only with the filter macro.
- `i_cfg_en`  in  1  global count enable.
- `i_cfg_mask`  in  N_EV  per-channel count enable.
- `i_cmd_valid`  in  1  command request.
- `o_cmd_ready`  out  1  command accept.
- `i_cmd_op`  in  2  command: 00 read, 01 clear one, 10 clear all, 11 snapshot.
- `i_cmd_addr`  in  ADDR_W  channel index for read / clear one.
- `o_rsp_valid`  out  1  read-response pulse.
- `o_rsp_data`  out  CNT_W  shadow counter value.
- `o_rsp_ovf`  out  1  shadow overflow flag.
- `o_ovf`  out  N_EV  live sticky overflow flags.
- `o_busy`  out  1  clear-all sweep in progress.

## Operation
- Increment term for channel k: `inc[k] = i_dbg_next & i_ev[k] & i_cfg_en & i_cfg_mask[k] & pc_ok`.
  - `pc_ok` is 1 when the filter macro is absent.
- Counters are unsigned and wrap modulo 2^CNT_W.
  - An increment from all-ones writes 0 and sets `o_ovf[k]`.
  - `o_ovf[k]` stays set until channel k is cleared.
- FSM states: IDLE, CLR_ALL.
  - IDLE: `o_cmd_ready` is 1.
  - Read: drives shadow[addr] and shadow_ovf[addr] on the response one cycle later. State stays IDLE.
  - Clear one: zeroes counter[addr] and `o_ovf[addr]`. State stays IDLE.
  - Snapshot: copies every counter and overflow flag into the shadow bank at the accepting edge. State stays IDLE.
  - Clear all: enters CLR_ALL with sweep index 0.
  - CLR_ALL: `o_cmd_ready` = 0 and `o_busy` = 1. Each cycle, counter[idx] and `o_ovf[idx]` are zeroed and idx increments.
  - Return to IDLE on the edge that clears channel N_EV-1; a sweep takes N_EV cycles.
- Address >= N_EV: read returns data 0, ovf 0; clear one does nothing. The response is still produced.
- A clear (one or sweep) and an increment on the same channel in the same cycle: the clear wins and the counter becomes 0.
- During a sweep, channels keep counting; channels already cleared accumulate again.
- Shadow values change only on a snapshot. Clears do not touch the shadow bank.

## Timing
- Reset values:
  - all counters, shadow values, overflow flags and shadow overflow flags: 0.
  - `o_rsp_valid` = 0, `o_rsp_data` = 0, `o_rsp_ovf` = 0, `o_busy` = 0.
  - `o_cmd_ready` = 1; FSM in IDLE.
- Reset mid-sweep aborts the sweep and applies the reset values.
- Handshake: a command is accepted on a rising edge where `i_cmd_valid` and `o_cmd_ready` are both 1. `i_cmd_op` and `i_cmd_addr` are sampled at that edge.
- An event at edge t is visible in the counter after edge t (1-cycle latency).
- A snapshot accepted at edge t captures counter values from before edge t, so events at edge t are excluded from the shadow.
- A read accepted at edge t:
  - `o_rsp_valid` is 1 for exactly the cycle after t.
  - `o_rsp_data` and `o_rsp_ovf` hold their values until the next response.
- Back-to-back reads give one response per cycle.
- A snapshot followed by a read on the next cycle returns the new shadow value.

## Configuration
- `RISCVSYS_EVCNT_PCFILT_EN` defined: `pc_ok = (i_pc >= i_pc_lo) && (i_pc <= i_pc_hi)`, unsigned compare.
  - If `i_pc_lo` > `i_pc_hi`, nothing counts.
- Not defined: `pc_ok` = 1, and `i_pc`, `i_pc_lo`, `i_pc_hi` are ignored.

## Test plan
- Reset → counting: hold `i_resetn` = 0 for 2 cycles, then release. Drive 5 retire cycles with `i_ev[0]` = 1, mask all ones, `i_cfg_en` = 1. Snapshot, then read addr 0 → `o_rsp_valid` for 1 cycle, data 5, ovf 0.
- Wrap: CNT_W = 4, 17 events on channel 3 → counter reads 1 and `o_ovf[3]` = 1. Clear one at addr 3 → counter 0 and `o_ovf[3]` = 0.
- Gating: `i_dbg_next` = 0, or `i_cfg_mask[2]` = 0, or `i_cfg_en` = 0 with `i_ev[2]` = 1 for 10 cycles → snapshot read of channel 2 returns 0.
- Clear-all sweep with N_EV = 49:
  - `o_cmd_ready` is low for exactly 49 cycles.
  - An event on channel 0 on sweep cycle 10 → channel 0 = 1 after the sweep; all other channels 0.
- Collision: clear one at addr 1 in the same cycle as an increment on channel 1 → counter 0. A read at addr 60 → data 0, ovf 0, valid pulse present.
- With `RISCVSYS_EVCNT_PCFILT_EN` defined, lo = 0x100, hi = 0x1FC:
  - events at pc 0x0FC, 0x100, 0x1FC and 0x200 → count 2.
  - with lo = 0x200, hi = 0x100 → count 0.

Source files
------------

// File: rtl/riscvsys_evcnt.sv
// ============================================================================
// riscvsys_evcnt: retire-qualified event counter bank with snapshot shadow
// bank and a command/response debug port. Optional PC window filter:
// RISCVSYS_EVCNT_PCFILT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module riscvsys_evcnt #(
  parameter int N_EV   = 49,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic [N_EV-1:0]   i_ev,
  input  logic              i_dbg_next,
  input  logic [31:0]       i_pc,
  input  logic [31:0]       i_pc_lo,
  input  logic [31:0]       i_pc_hi,
  input  logic              i_cfg_en,
  input  logic [N_EV-1:0]   i_cfg_mask,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  output logic              o_rsp_valid,
  output logic [CNT_W-1:0]  o_rsp_data,
  output logic              o_rsp_ovf,
  output logic [N_EV-1:0]   o_ovf,
  output logic              o_busy
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_CLR1  = 2'b01;
  localparam logic [1:0] OP_CLRA  = 2'b10;
  localparam logic [1:0] OP_SNAP  = 2'b11;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CLR_ALL = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   idx, idx_nxt;

  logic [CNT_W-1:0]    cnt        [N_EV];
  logic [CNT_W-1:0]    shadow     [N_EV];
  logic [N_EV-1:0]     ovf;
  logic [N_EV-1:0]     shadow_ovf;

  logic                accept;
  logic                pc_ok;
  logic [N_EV-1:0]     inc;
  logic [N_EV-1:0]     clr;
  logic [CNT_W-1:0]    rd_data;
  logic                rd_ovf;

`ifdef RISCVSYS_EVCNT_PCFILT_EN
  assign pc_ok = (i_pc >= i_pc_lo) && (i_pc <= i_pc_hi);
`else
  logic unused_pc;
  assign pc_ok     = 1'b1;
  assign unused_pc = ^{i_pc, i_pc_lo, i_pc_hi};
`endif

  assign o_cmd_ready = (state == IDLE);
  assign o_busy      = (state == CLR_ALL);
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign o_ovf       = ovf;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (accept && (i_cmd_op == OP_CLRA)) begin
          state_nxt = CLR_ALL;
          idx_nxt   = '0;
        end
      end
      CLR_ALL: begin
        if (idx == ADDR_W'(N_EV - 1)) state_nxt = IDLE;
        else                          idx_nxt   = idx + ADDR_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear beats increment: an out-of-range address matches no channel.
  always_comb begin
    inc     = '0;
    clr     = '0;
    rd_data = '0;
    rd_ovf  = 1'b0;
    for (int k = 0; k < N_EV; k++) begin
      inc[k] = i_dbg_next & i_ev[k] & i_cfg_en & i_cfg_mask[k] & pc_ok;
      clr[k] = (accept && (i_cmd_op == OP_CLR1) && (i_cmd_addr == ADDR_W'(k)))
             || ((state == CLR_ALL) && (idx == ADDR_W'(k)));
      if (i_cmd_addr == ADDR_W'(k)) begin
        rd_data = shadow[k];
        rd_ovf  = shadow_ovf[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      for (int k = 0; k < N_EV; k++) begin
        cnt[k]    <= '0;
        shadow[k] <= '0;
      end
      ovf        <= '0;
      shadow_ovf <= '0;
    end else begin
      for (int k = 0; k < N_EV; k++) begin
        if (clr[k]) begin
          cnt[k] <= '0;
          ovf[k] <= 1'b0;
        end else if (inc[k]) begin
          cnt[k] <= cnt[k] + CNT_W'(1);
          if (&cnt[k]) ovf[k] <= 1'b1;
        end
      end
      // Snapshot takes pre-edge values, so same-edge events are excluded.
      if (accept && (i_cmd_op == OP_SNAP)) begin
        for (int k = 0; k < N_EV; k++) shadow[k] <= cnt[k];
        shadow_ovf <= ovf;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_ovf   <= 1'b0;
    end else begin
      o_rsp_valid <= accept && (i_cmd_op == OP_READ);
      if (accept && (i_cmd_op == OP_READ)) begin
        o_rsp_data <= rd_data;
        o_rsp_ovf  <= rd_ovf;
      end
    end
  end

endmodule

`default_nettype wire
